// File: rtl/sine_lut_sequencer.sv
// Table-lookup oscillator sequencer: one ROM read per sample period, phase stepping,
// and a tagged valid pipeline that realigns ROM data into a strobed sample stream.
module sine_lut_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 11,
  parameter int DIV_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [ADDR_W-1:0] step,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              wrap,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] phase;
  logic [ADDR_W:0]   sum;
  logic [DIV_W-1:0]  cnt, p_lat, div_eff;
  logic [RD_LAT:0]   vld_pipe, wrp_pipe;
  logic              issue;

  assign sum     = {1'b0, phase} + {1'b0, step};
  assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
  // Stage 0 of the valid pipeline is the registered read strobe itself.
  assign mem_ena  = vld_pipe[0];
  assign mem_wea  = 1'b0;
  assign mem_dina = '0;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:    if (enable) begin
                 issue    = 1'b1;
                 state_nx = RUN;
               end
      RUN:     if (!enable) state_nx = DRAIN;
               else if (cnt == p_lat - DIV_W'(1)) issue = 1'b1;
      DRAIN:   if (vld_pipe == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      cnt          <= '0;
      p_lat        <= DIV_W'(1);
      vld_pipe     <= '0;
      wrp_pipe     <= '0;
      mem_addra    <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      state        <= state_nx;
      vld_pipe     <= {vld_pipe[RD_LAT-1:0], issue};
      wrp_pipe     <= {wrp_pipe[RD_LAT-1:0], issue & sum[ADDR_W]};
      sample_valid <= vld_pipe[RD_LAT];
      wrap         <= wrp_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) sample_out <= mem_douta;
      // Period and step are only sampled here, so a retune never produces a glitched period.
      if (issue) begin
        mem_addra <= phase;
        phase     <= sum[ADDR_W-1:0];
        cnt       <= '0;
        p_lat     <= div_eff;
      end else if (state == RUN) begin
        cnt <= cnt + DIV_W'(1);
      end else if (state_nx == IDLE) begin
        phase <= '0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sine_lut_sequencer.sv
// Scoreboard bench: two sequencers (read latency 1 and 2) share stimulus; a timed
// reference model predicts every read and sample, a negedge monitor checks them.
module tb_sine_lut_sequencer;
  localparam int AW  = 8;
  localparam int DW  = 11;
  localparam int DVW = 16;

  logic           clk = 1'b0;
  logic           rst_n, enable;
  logic [DVW-1:0] divisor;
  logic [AW-1:0]  step;

  logic          ena_w [2], wea_w [2], sv_w [2], wrap_w [2], busy_w [2];
  logic [AW-1:0] addr_w [2];
  logic [DW-1:0] dina_w [2], douta_w [2], sout_w [2];
  logic [DW-1:0] rom [256];

  typedef struct {
    int            t;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wrap;
  } exp_t;

  exp_t rq [2][$];
  exp_t sq [2][$];
  exp_t me, ne;

  int cyc = 0, vectors = 0, errors = 0;
  int m_phase = 0, m_next = 0, m_stop = -100;
  bit m_run = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sine_lut_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(DVW), .RD_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .divisor(divisor), .step(step),
      .mem_ena(ena_w[g]), .mem_wea(wea_w[g]), .mem_addra(addr_w[g]), .mem_dina(dina_w[g]),
      .mem_douta(douta_w[g]), .sample_out(sout_w[g]), .sample_valid(sv_w[g]),
      .wrap(wrap_w[g]), .busy(busy_w[g]));
    if (g == 0) begin : g_rom1
      logic [DW-1:0] d1;
      always @(posedge clk) if (ena_w[g]) d1 <= rom[addr_w[g]];
      assign douta_w[g] = d1;
    end else begin : g_rom2
      logic [DW-1:0] d1, d2;
      always @(posedge clk) begin
        if (ena_w[g]) d1 <= rom[addr_w[g]];
        d2 <= d1;
      end
      assign douta_w[g] = d2;
    end
  end

  // Reference model: a read happens when enable is first seen, then every P edges.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        rq[g].delete();
        sq[g].delete();
      end
      m_run = 1'b0; m_phase = 0; m_stop = cyc - 100;
    end else if (m_run && !enable) begin
      m_run = 1'b0; m_phase = 0; m_stop = cyc;
    end else if (enable && (!m_run || cyc == m_next)) begin
      ne.addr = AW'(m_phase);
      ne.data = rom[m_phase];
      ne.wrap = (m_phase + int'(step)) > 255;
      for (int g = 0; g < 2; g++) begin
        ne.t = cyc;
        rq[g].push_back(ne);
        ne.t = cyc + g + 2;
        sq[g].push_back(ne);
      end
      m_phase = (m_phase + int'(step)) % 256;
      m_next  = cyc + ((divisor == 0) ? 1 : int'(divisor));
      m_run   = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        vectors++;
        if (ena_w[g] !== 1'b0 || addr_w[g] !== '0 || sout_w[g] !== '0 || sv_w[g] !== 1'b0 ||
            wrap_w[g] !== 1'b0 || busy_w[g] !== 1'b0) begin
          errors++;
          $display("FAIL rst_outputs lat%0d cyc %0d: ena=%b addr=%0d sample=%0d valid=%b wrap=%b busy=%b, required all 0",
                   g + 1, cyc, ena_w[g], addr_w[g], sout_w[g], sv_w[g], wrap_w[g], busy_w[g]);
        end
      end else begin
        while (rq[g].size() != 0 && rq[g][0].t < cyc) begin
          vectors++; errors++;
          me = rq[g].pop_front();
          $display("FAIL missing_read lat%0d: no mem_ena at cyc %0d, required addr %0d", g + 1, me.t, me.addr);
        end
        while (sq[g].size() != 0 && sq[g][0].t < cyc) begin
          vectors++; errors++;
          me = sq[g].pop_front();
          $display("FAIL missing_sample lat%0d: no sample_valid at cyc %0d, required %0d", g + 1, me.t, me.data);
        end
        if (ena_w[g] === 1'b1) begin
          vectors++;
          if (rq[g].size() == 0) begin
            errors++;
            $display("FAIL extra_read lat%0d cyc %0d: addr %0d, required no read", g + 1, cyc, addr_w[g]);
          end else begin
            me = rq[g].pop_front();
            if (me.t != cyc || me.addr !== addr_w[g]) begin
              errors++;
              $display("FAIL read lat%0d: got addr %0d at cyc %0d, required addr %0d at cyc %0d",
                       g + 1, addr_w[g], cyc, me.addr, me.t);
            end
          end
        end
        if (sv_w[g] === 1'b1) begin
          vectors++;
          if (sq[g].size() == 0) begin
            errors++;
            $display("FAIL extra_sample lat%0d cyc %0d: sample %0d, required no strobe", g + 1, cyc, sout_w[g]);
          end else begin
            me = sq[g].pop_front();
            if (me.t != cyc || me.data !== sout_w[g] || me.wrap !== wrap_w[g]) begin
              errors++;
              $display("FAIL sample lat%0d: got %0d wrap %b at cyc %0d, required %0d wrap %b at cyc %0d",
                       g + 1, sout_w[g], wrap_w[g], cyc, me.data, me.wrap, me.t);
            end
          end
        end else if (wrap_w[g] !== 1'b0) begin
          vectors++; errors++;
          $display("FAIL wrap_no_valid lat%0d cyc %0d: wrap %b, required 0", g + 1, cyc, wrap_w[g]);
        end
        vectors++;
        if (wea_w[g] !== 1'b0 || dina_w[g] !== '0) begin
          errors++;
          $display("FAIL tieoff lat%0d cyc %0d: wea=%b dina=%0d, required 0/0", g + 1, cyc, wea_w[g], dina_w[g]);
        end
        if (m_run || cyc >= m_stop + g + 3) begin
          vectors++;
          if (busy_w[g] !== m_run) begin
            errors++;
            $display("FAIL busy lat%0d cyc %0d: got %b, required %b", g + 1, cyc, busy_w[g], m_run);
          end
        end
      end
    end
  end

  task automatic run(input int div, input int stp, input int n);
    @(negedge clk);
    divisor = DVW'(div);
    step    = AW'(stp);
    enable  = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic stop();
    enable = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    rst_n = 1'b0; enable = 1'b0; divisor = '0; step = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(4, 1, 60);   stop();
    run(2, 64, 40);  stop();
    run(0, 7, 30);   run(1, 255, 30); stop();
    run(1, 3, 200);  stop();
    // Long period, drop enable one cycle after the second read.
    @(negedge clk);
    divisor = DVW'(1493); step = AW'(9); enable = 1'b1;
    repeat (1494) @(negedge clk);
    stop();
    run(5, 2, 20);   stop();
    run(8, 1, 21);   run(3, 5, 30); stop();
    run(1, 17, 13);  pulse_reset(); repeat (10) @(negedge clk); stop();
    for (int k = 0; k < 40; k++) begin
      run($urandom_range(0, 20), $urandom_range(0, 255), $urandom_range(5, 60));
      case ($urandom_range(0, 3))
        0:       stop();
        1:       pulse_reset();
        default: ;
      endcase
    end
    stop();
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sine_lut_sequencer.md
# sine_lut_sequencer

Sequencer that drives the single-port sine lookup block memory (256 x 11-bit, registered read) as a table-lookup oscillator. It issues one ROM read per programmable sample period, advances a phase address by a programmable step (frequency control), and realigns the ROM output into a registered sample stream with a valid strobe and a wrap marker. It sits between the block memory instance and the downstream sample consumer (DAC/PWM/audio path). It replaces hand-timed address stepping with a clean start/stop/drain control interface.

## Interface
- ADDR_W, 8, ROM address width; phase wraps modulo 2^ADDR_W
- DATA_W, 11, ROM data width
- DIV_W, 16, sample-period divisor width
- RD_LAT, 1, ROM read latency in cycles; legal values 1 or 2

- clk  in  1  system clock, 100 MHz, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; high starts or continues generation, low requests stop
- divisor  in  DIV_W  sample period P in clocks; 0 is treated as 1
- step  in  ADDR_W  phase increment per sample
- mem_ena  out  1  ROM enable; one-cycle pulse per read
- mem_wea  out  1  ROM write enable; constant 0
- mem_addra  out  ADDR_W  ROM address, registered
- mem_dina  out  DATA_W  ROM write data; constant 0
- mem_douta  in  DATA_W  ROM read data
- sample_out  out  DATA_W  last captured sample; holds between strobes
- sample_valid  out  1  one-cycle strobe; sample_out is new this cycle
- wrap  out  1  coincident with sample_valid; this sample's read made the phase wrap
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: phase=0, cnt=0. If enable=1 at an edge, issue read 0 and move to RUN.
- Issue read, at a single edge: mem_ena<=1 and mem_addra<=phase; phase<=(phase+step) mod 2^ADDR_W; cnt<=0; P latched from divisor, with 0 mapped to 1; wrap tag = carry out of phase+step. At every edge with no issue, mem_ena<=0.
- RUN, enable=1: cnt increments each edge. When cnt==P_latched-1, issue the next read. divisor and step changes take effect only at an issue edge, so there are no glitched periods.
- RUN, enable=0 at any edge: go to DRAIN. No read is issued at that edge, even if cnt==P-1.
- DRAIN: no reads. Wait until the valid pipeline is empty (at most RD_LAT+1 cycles), then go to IDLE with phase=0. enable is ignored in DRAIN.
- Valid pipeline: a shift register of depth RD_LAT+1 carries {valid, wrap tag}, so P=1 (one read per clock) is fully supported.
- Capture: mem_douta is registered into sample_out when the tagged read's data is valid.
- Reset (async, any state, including mid-read or mid-drain): state=IDLE; phase, cnt, pipeline, mem_ena, mem_addra, sample_out, sample_valid, wrap and busy all go to 0. In-flight samples are discarded.
- Tie-offs: mem_wea=0 and mem_dina=0 at all times.

## Timing
- Read latency: if mem_ena is high in cycle c, mem_douta is valid in cycle c+RD_LAT. sample_out and sample_valid are high in cycle c+RD_LAT+1.
- Startup: enable first seen high at edge e puts mem_ena high in the cycle after e. The first sample_valid follows RD_LAT+1 cycles later.
- Read spacing: reads occur exactly P cycles apart. Sample strobes are likewise exactly P cycles apart.
- Stopping: enable low at edge s means no read after s. Every read issued before s still produces its sample_valid. busy falls at most RD_LAT+2 cycles after s.
- Phase boundary: phase wraps modulo 2^ADDR_W with no gap. For example, with step=3 and phase=254, the address sequence is 254, 1.

## Test plan
- Basic stepping (bench ROM model returns douta=addr, RD_LAT=1). Stimulus: step=1, divisor=4, enable high. Required: addresses 0,1,2,… every 4 cycles; sample_valid every 4 cycles, 2 cycles after each mem_ena; sample_out = 0,1,2,…
- Wrap marker. Stimulus: step=64, divisor=2. Required: address sequence 0,64,128,192,0,…; wrap=1 only on the samples from address 192; none missing at the wrap.
- Full rate. Stimulus: divisor=0 and divisor=1, RD_LAT=2. Required: mem_ena continuously high; sample_valid continuously high from 3 cycles after the first read.
- Stop and drain. Stimulus: deassert enable 1 cycle after an issue, with P=1493. Required: no further mem_ena; the outstanding sample is delivered; busy drops; restart begins again at address 0.
- Live retune. Stimulus: change divisor 8→3 and step 1→5 mid-period. Required: the current period completes at 8 cycles; the new values apply from the next issue.
- Async reset. Stimulus: assert rst_n low for 1 cycle while a read is in flight. Required: all outputs 0 immediately; no sample_valid from the killed read; state is IDLE.
